riscv_insn_decode: RTL and testbench

- Front end for the RISC-V execution unit: accepts 32-bit instruction words over a valid/ready handshake and decodes opcode/funct3/funct7.
- Reads rs1/rs2 operands from a local 32-entry register file and presents fields and operands to the exec unit.
- Captures the exec unit's registered rd result and writes it back.
- Also executes LUI locally, flags unsupported encodings, and emits one retire pulse per instruction.

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/riscv_regfile.sv | 43 ++++
 rtl/riscv_insn_decode.sv | 186 ++++++++++++++++++
 tb/tb_riscv_insn_decode.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared decode constants and types for the RISC-V decoder and the exec unit.
package riscv_pkg;

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    // funct10 = {funct7, funct3}
    localparam logic [9:0] F10_ADD  = 10'b0000000_000;
    localparam logic [9:0] F10_SUB  = 10'b0100000_000;
    localparam logic [9:0] F10_SLL  = 10'b0000000_001;
    localparam logic [9:0] F10_SLT  = 10'b0000000_010;
    localparam logic [9:0] F10_SLTU = 10'b0000000_011;
    localparam logic [9:0] F10_XOR  = 10'b0000000_100;
    localparam logic [9:0] F10_SRL  = 10'b0000000_101;
    localparam logic [9:0] F10_SRA  = 10'b0100000_101;
    localparam logic [9:0] F10_OR   = 10'b0000000_110;
    localparam logic [9:0] F10_AND  = 10'b0000000_111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } dec_state_e;

    typedef enum logic [1:0] {
        K_OP  = 2'd0,
        K_LUI = 2'd1,
        K_ILL = 2'd2
    } insn_kind_e;

    typedef logic [4:0] reg_idx_t;

    // The exec unit implements only these OP operations.
    function automatic logic op_supported(input logic [9:0] f10);
        return (f10 == F10_ADD) || (f10 == F10_SUB) || (f10 == F10_XOR) ||
               (f10 == F10_OR)  || (f10 == F10_AND);
    endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 31-entry integer register file: one write port, three combinational read ports, x0 hardwired to 0.
module riscv_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic [4:0]      raddr3,
    output logic [XLEN-1:0] rdata3
);

    logic [XLEN-1:0] regs_q [1:31];
    logic [XLEN-1:0] regs_d [1:31];

    always_comb begin
        for (int i = 1; i < 32; i++) begin
            regs_d[i] = (we && (waddr == reg_idx_t'(i))) ? wdata : regs_q[i];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : regs_q[raddr2];
    assign rdata3 = (raddr3 == 5'd0) ? '0 : regs_q[raddr3];

endmodule

// File: rtl/riscv_insn_decode.sv
// Single-issue RISC-V decode front end: handshake, operand read, LUI, writeback, retire.
// Define RISCV_DECODE_INSTRET_EN to add the 64-bit instret counter and its clear input.
//
// state | meaning
// IDLE  | ready for a new instruction word
// EXEC  | fields/operands presented to the exec unit for one cycle
// WB    | write back result (OP/LUI) or flag illegal; retire pulse
module riscv_insn_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            insn_valid,
    output logic            insn_ready,
    input  logic [31:0]     insn,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] exec_rd,
    output logic            retire,
    output logic            illegal_insn,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
`ifdef RISCV_DECODE_INSTRET_EN
    ,
    input  logic            instret_clr,
    output logic [63:0]     instret
`endif
);

    dec_state_e      state_q, state_d;
    insn_kind_e      kind_q, kind_d;
    reg_idx_t        rd_q, rd_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [6:0]      opcode_q, opcode_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [6:0]      funct7_q, funct7_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic            retire_q, retire_d;
    logic            illegal_q, illegal_d;

    logic [XLEN-1:0] rf_rs1, rf_rs2;
    logic            wb_we;
    logic [XLEN-1:0] wb_data;
    logic signed [31:0] lui32;
    logic [XLEN-1:0] lui_val;

    assign insn_ready = (state_q == ST_IDLE);
    assign lui32      = {insn[31:12], 12'b0};
    // Signed cast sign-extends bit 31 when XLEN is 64.
    assign lui_val    = XLEN'(lui32);

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        rd_d      = rd_q;
        result_d  = result_q;
        opcode_d  = opcode_q;
        funct3_d  = funct3_q;
        funct7_d  = funct7_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        retire_d  = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (insn_valid) begin
                    rd_d = insn[11:7];
                    if ((insn[6:0] == OPC_OP) && op_supported({insn[31:25], insn[14:12]})) begin
                        kind_d   = K_OP;
                        opcode_d = insn[6:0];
                        funct3_d = insn[14:12];
                        funct7_d = insn[31:25];
                        rs1_d    = rf_rs1;
                        rs2_d    = rf_rs2;
                        state_d  = ST_EXEC;
                    end else if (insn[6:0] == OPC_LUI) begin
                        kind_d   = K_LUI;
                        result_d = lui_val;
                        retire_d = 1'b1;
                        state_d  = ST_WB;
                    end else begin
                        kind_d    = K_ILL;
                        retire_d  = 1'b1;
                        illegal_d = 1'b1;
                        state_d   = ST_WB;
                    end
                end
            end
            ST_EXEC: begin
                // Clear opcode so the exec unit never re-executes a stale OP.
                opcode_d = 7'b0;
                retire_d = 1'b1;
                state_d  = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            kind_q    <= K_ILL;
            rd_q      <= '0;
            result_q  <= '0;
            opcode_q  <= '0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            opcode_q  <= opcode_d;
            funct3_q  <= funct3_d;
            funct7_q  <= funct7_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            retire_q  <= retire_d;
            illegal_q <= illegal_d;
        end
    end

    assign wb_we   = (state_q == ST_WB) && (kind_q != K_ILL);
    assign wb_data = (kind_q == K_OP) ? exec_rd : result_q;

    riscv_regfile #(.XLEN(XLEN)) u_regfile (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (wb_we),
        .waddr   (rd_q),
        .wdata   (wb_data),
        .raddr1  (insn[19:15]),
        .rdata1  (rf_rs1),
        .raddr2  (insn[24:20]),
        .rdata2  (rf_rs2),
        .raddr3  (dbg_raddr),
        .rdata3  (dbg_rdata)
    );

    assign opcode       = opcode_q;
    assign funct3       = funct3_q;
    assign funct7       = funct7_q;
    assign rs1          = rs1_q;
    assign rs2          = rs2_q;
    assign retire       = retire_q;
    assign illegal_insn = illegal_q;

`ifdef RISCV_DECODE_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q;
        if (instret_clr) begin
            instret_d = '0;
        end else if (retire_q) begin
            instret_d = instret_q + 64'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_riscv_insn_decode.sv
// Directed bench for riscv_insn_decode with a small behavioural exec unit; honours RISCV_DECODE_INSTRET_EN.
module tb_riscv_insn_decode;
    import riscv_pkg::*;

    localparam int XLEN = 32;

    logic            clock;
    logic            reset_n;
    logic            insn_valid;
    logic            insn_ready;
    logic [31:0]     insn;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] exec_rd;
    logic            retire;
    logic            illegal_insn;
    logic [4:0]      dbg_raddr;
    logic [XLEN-1:0] dbg_rdata;
`ifdef RISCV_DECODE_INSTRET_EN
    logic            instret_clr;
    logic [63:0]     instret;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    riscv_insn_decode #(.XLEN(XLEN)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .insn_valid   (insn_valid),
        .insn_ready   (insn_ready),
        .insn         (insn),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7       (funct7),
        .rs1          (rs1),
        .rs2          (rs2),
        .exec_rd      (exec_rd),
        .retire       (retire),
        .illegal_insn (illegal_insn),
        .dbg_raddr    (dbg_raddr),
        .dbg_rdata    (dbg_rdata)
`ifdef RISCV_DECODE_INSTRET_EN
        ,
        .instret_clr  (instret_clr),
        .instret      (instret)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Exec unit model: samples fields at the end of EXEC, result registered.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exec_rd <= '0;
        end else if (opcode == OPC_OP) begin
            case ({funct7, funct3})
                F10_ADD: exec_rd <= rs1 + rs2;
                F10_SUB: exec_rd <= rs1 - rs2;
                F10_XOR: exec_rd <= rs1 ^ rs2;
                F10_OR:  exec_rd <= rs1 | rs2;
                F10_AND: exec_rd <= rs1 & rs2;
                default: exec_rd <= 32'hDEAD_BEEF;
            endcase
        end
    end

    typedef struct {
        logic [31:0] word;
        logic [4:0]  chk_reg;
        logic [31:0] exp_val;
        logic        exp_ill;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic dbg_read(input logic [4:0] r, output logic [XLEN-1:0] v);
        dbg_raddr = r;
        #1;
        v = dbg_rdata;
    endtask

    // Issue one instruction from a negedge; returns retire latency in edges after accept.
    task automatic run_insn(input logic [31:0] w, output int lat, output logic ill,
                            output logic busy_ok);
        int n;
        n = 0;
        while (!insn_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("accept_ready", {63'd0, insn_ready}, 64'd1);
        insn       = w;
        insn_valid = 1'b1;
        @(posedge clock);
        #1;
        insn_valid = 1'b0;
        lat     = 0;
        ill     = 1'b0;
        busy_ok = 1'b1;
        do begin
            @(negedge clock);
            lat++;
            if (insn_ready) busy_ok = 1'b0;
        end while (!retire && lat < 10);
        ill = illegal_insn;
        @(negedge clock);
    endtask

    vec_t vecs[$];
    logic [XLEN-1:0] v;
    int   lat;
    logic ill;
    logic busy_ok;
    logic all_zero;

    initial begin
        reset_n    = 1'b0;
        insn_valid = 1'b0;
        insn       = '0;
        dbg_raddr  = '0;
`ifdef RISCV_DECODE_INSTRET_EN
        instret_clr = 1'b0;
`endif
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        all_zero = 1'b1;
        for (int r = 1; r < 32; r++) begin
            dbg_read(5'(r), v);
            if (v !== '0) all_zero = 1'b0;
        end
        check("reset_regs_zero", {63'd0, all_zero}, 64'd1);
        check("reset_ready", {63'd0, insn_ready}, 64'd1);
        check("reset_retire", {63'd0, retire}, 64'd0);
        check("reset_illegal", {63'd0, illegal_insn}, 64'd0);
        check("reset_opcode", {57'd0, opcode}, 64'd0);
        check("reset_rs1", {32'd0, rs1}, 64'd0);
`ifdef RISCV_DECODE_INSTRET_EN
        check("reset_instret", instret, 64'd0);
`endif

        vecs.push_back('{32'h123452B7, 5'd5,  32'h1234_5000, 1'b0, 1}); // LUI x5
        vecs.push_back('{32'h000050B7, 5'd1,  32'h0000_5000, 1'b0, 1}); // LUI x1
        vecs.push_back('{32'h00003137, 5'd2,  32'h0000_3000, 1'b0, 1}); // LUI x2
        vecs.push_back('{32'h002081B3, 5'd3,  32'h0000_8000, 1'b0, 2}); // ADD x3,x1,x2
        vecs.push_back('{32'h40110233, 5'd4,  32'hFFFF_E000, 1'b0, 2}); // SUB x4,x2,x1
        vecs.push_back('{32'h0020C333, 5'd6,  32'h0000_6000, 1'b0, 2}); // XOR x6
        vecs.push_back('{32'h0020E3B3, 5'd7,  32'h0000_7000, 1'b0, 2}); // OR x7
        vecs.push_back('{32'h0020F433, 5'd8,  32'h0000_1000, 1'b0, 2}); // AND x8
        vecs.push_back('{32'h00208033, 5'd0,  32'h0000_0000, 1'b0, 2}); // ADD x0
        vecs.push_back('{32'h00209533, 5'd10, 32'h0000_0000, 1'b1, 1}); // SLL x10
        vecs.push_back('{32'h00508593, 5'd11, 32'h0000_0000, 1'b1, 1}); // ADDI x11
        vecs.push_back('{32'h4020D633, 5'd12, 32'h0000_0000, 1'b1, 1}); // SRA x12

        foreach (vecs[i]) begin
            run_insn(vecs[i].word, lat, ill, busy_ok);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("v%0d_illegal", i), {63'd0, ill}, {63'd0, vecs[i].exp_ill});
            check($sformatf("v%0d_busy", i), {63'd0, busy_ok}, 64'd1);
            dbg_read(vecs[i].chk_reg, v);
            check($sformatf("v%0d_rd_value", i), {32'd0, v}, {32'd0, vecs[i].exp_val});
        end

        dbg_read(5'd1, v);
        check("x1_intact", {32'd0, v}, 64'h5000);
        dbg_read(5'd3, v);
        check("x3_intact", {32'd0, v}, 64'h8000);
        dbg_read(5'd5, v);
        check("x5_intact", {32'd0, v}, 64'h1234_5000);
        check("opcode_idle_zero", {57'd0, opcode}, 64'd0);

`ifdef RISCV_DECODE_INSTRET_EN
        check("instret_count", instret, 64'd12);
        @(negedge clock);
        instret_clr = 1'b1;
        @(negedge clock);
        instret_clr = 1'b0;
        check("instret_clear", instret, 64'd0);
`endif

        // Reset while ADD x9,x1,x2 sits in EXEC.
        insn       = 32'h002084B3;
        insn_valid = 1'b1;
        @(posedge clock);
        #1;
        insn_valid = 1'b0;
        check("exec_opcode", {57'd0, opcode}, {57'd0, OPC_OP});
        check("exec_rs1", {32'd0, rs1}, 64'h5000);
        check("exec_rs2", {32'd0, rs2}, 64'h3000);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rst_ready", {63'd0, insn_ready}, 64'd1);
        check("rst_retire", {63'd0, retire}, 64'd0);
        check("rst_opcode", {57'd0, opcode}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        dbg_read(5'd9, v);
        check("rst_x9_zero", {32'd0, v}, 64'd0);
        dbg_read(5'd1, v);
        check("rst_x1_zero", {32'd0, v}, 64'd0);
        check("rst_retire_after", {63'd0, retire}, 64'd0);

`ifdef RISCV_DECODE_INSTRET_EN
        check("instret_after_reset", instret, 64'd0);
        run_insn(32'h000050B7, lat, ill, busy_ok);
        run_insn(32'h00003137, lat, ill, busy_ok);
        run_insn(32'h002081B3, lat, ill, busy_ok);
        check("instret_three", instret, 64'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
